// File: rtl/parking_lcd_text.sv
// Character formatter for the parking LCD: free-space count and
// timed event messages on two 16-character lines.
module parking_lcd_text #(
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic         iCLK,
    input  logic         iRST_N,
    input  logic [6:0]   iFREE,
    input  logic         iCAR_IN,
    input  logic         iCAR_OUT,
    input  logic         iDENIED,
    output logic [127:0] line1,
    output logic [127:0] line2,
    output logic         oBUSY
);

    localparam int TW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);

    localparam logic [103:0] L1_PREFIX = "FREE SPACES: ";
    localparam logic [127:0] L1_RST    = "FREE SPACES: ---";
    localparam logic [127:0] L2_RST    = "STATUS: INIT    ";
    localparam logic [127:0] L2_OPEN   = "STATUS: OPEN    ";
    localparam logic [127:0] L2_FULL   = "STATUS: FULL    ";
    localparam logic [127:0] MSG_IN    = "CAR ENTERED     ";
    localparam logic [127:0] MSG_OUT   = "CAR EXITED      ";
    localparam logic [127:0] MSG_DEN   = "ENTRY DENIED    ";

    typedef enum logic [1:0] {CIDLE, SHIFT, LOAD} conv_e;
    typedef enum logic {STATUS, EVENT} disp_e;

    conv_e          conv_q, conv_d;
    disp_e          disp_q, disp_d;
    logic [6:0]     cap_q, cap_d;
    logic [6:0]     bin_q, bin_d;
    logic [11:0]    bcd_q, bcd_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [6:0]     last_free_q, last_free_d;
    logic           conv_valid_q, conv_valid_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [127:0]   line1_q, line1_d;
    logic [127:0]   line2_q, line2_d;

    logic [11:0]    adj;
    logic           load;
    logic [7:0]     c_h, c_t, c_u;

    function automatic logic [3:0] dab(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [127:0] status_txt(input logic [6:0] v);
        return (v != 7'd0) ? L2_OPEN : L2_FULL;
    endfunction

    // Leading zeros blank to space; units digit always shown.
    always_comb begin
        c_u = {4'h3, bcd_q[3:0]};
        c_t = {4'h3, bcd_q[7:4]};
        c_h = {4'h3, bcd_q[11:8]};
        if (bcd_q[11:8] == 4'd0) begin
            c_h = 8'h20;
            if (bcd_q[7:4] == 4'd0) c_t = 8'h20;
        end
    end

    always_comb begin
        conv_d       = conv_q;
        cap_d        = cap_q;
        bin_d        = bin_q;
        bcd_d        = bcd_q;
        cnt_d        = cnt_q;
        last_free_d  = last_free_q;
        conv_valid_d = conv_valid_q;
        line1_d      = line1_q;
        adj          = '0;
        load         = 1'b0;

        unique case (conv_q)
            CIDLE: begin
                if (!conv_valid_q || iFREE != last_free_q) begin
                    cap_d  = iFREE;
                    bin_d  = iFREE;
                    bcd_d  = '0;
                    cnt_d  = '0;
                    conv_d = SHIFT;
                end
            end
            SHIFT: begin
                adj = {dab(bcd_q[11:8]), dab(bcd_q[7:4]), dab(bcd_q[3:0])};
                bcd_d = {adj[10:0], bin_q[6]};
                bin_d = {bin_q[5:0], 1'b0};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd6) conv_d = LOAD;
            end
            LOAD: begin
                line1_d      = {L1_PREFIX, c_h, c_t, c_u};
                last_free_d  = cap_q;
                conv_valid_d = 1'b1;
                load         = 1'b1;
                conv_d       = CIDLE;
            end
            default: conv_d = CIDLE;
        endcase
    end

    // Event pulses take line2 over from any state, even a same-edge load.
    always_comb begin
        disp_d  = disp_q;
        timer_d = timer_q;
        line2_d = line2_q;

        if (iDENIED) begin
            line2_d = MSG_DEN;
            timer_d = '0;
            disp_d  = EVENT;
        end else if (iCAR_IN) begin
            line2_d = MSG_IN;
            timer_d = '0;
            disp_d  = EVENT;
        end else if (iCAR_OUT) begin
            line2_d = MSG_OUT;
            timer_d = '0;
            disp_d  = EVENT;
        end else begin
            unique case (disp_q)
                STATUS: begin
                    if (load) line2_d = status_txt(cap_q);
                end
                EVENT: begin
                    timer_d = timer_q + TW'(1);
                    if (timer_q == HOLD_LAST) begin
                        timer_d = '0;
                        disp_d  = STATUS;
                        line2_d = status_txt(last_free_d);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            conv_q       <= CIDLE;
            disp_q       <= STATUS;
            cap_q        <= '0;
            bin_q        <= '0;
            bcd_q        <= '0;
            cnt_q        <= '0;
            last_free_q  <= '0;
            conv_valid_q <= 1'b0;
            timer_q      <= '0;
            line1_q      <= L1_RST;
            line2_q      <= L2_RST;
        end else begin
            conv_q       <= conv_d;
            disp_q       <= disp_d;
            cap_q        <= cap_d;
            bin_q        <= bin_d;
            bcd_q        <= bcd_d;
            cnt_q        <= cnt_d;
            last_free_q  <= last_free_d;
            conv_valid_q <= conv_valid_d;
            timer_q      <= timer_d;
            line1_q      <= line1_d;
            line2_q      <= line2_d;
        end
    end

    assign line1 = line1_q;
    assign line2 = line2_q;
    assign oBUSY = (conv_q != CIDLE);

endmodule

// File: tb/tb_parking_lcd_text.sv
// Directed bench for parking_lcd_text with a 10-cycle event hold.
module tb_parking_lcd_text;

    logic         iCLK;
    logic         iRST_N;
    logic [6:0]   iFREE;
    logic         iCAR_IN;
    logic         iCAR_OUT;
    logic         iDENIED;
    logic [127:0] line1;
    logic [127:0] line2;
    logic         oBUSY;

    int nchk = 0;
    int nerr = 0;
    int busy_cnt;

    localparam logic [127:0] L1_RST  = "FREE SPACES: ---";
    localparam logic [127:0] L2_RST  = "STATUS: INIT    ";
    localparam logic [127:0] L2_OPEN = "STATUS: OPEN    ";
    localparam logic [127:0] L2_FULL = "STATUS: FULL    ";
    localparam logic [127:0] M_IN    = "CAR ENTERED     ";
    localparam logic [127:0] M_OUT   = "CAR EXITED      ";
    localparam logic [127:0] M_DEN   = "ENTRY DENIED    ";

    parking_lcd_text #(.HOLD_CYCLES(10)) dut (
        .iCLK    (iCLK),
        .iRST_N  (iRST_N),
        .iFREE   (iFREE),
        .iCAR_IN (iCAR_IN),
        .iCAR_OUT(iCAR_OUT),
        .iDENIED (iDENIED),
        .line1   (line1),
        .line2   (line2),
        .oBUSY   (oBUSY)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got '%s' expected '%s'", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Change iFREE in idle; result must appear exactly on the 9th edge.
    task automatic conv(input logic [6:0] v, input logic [127:0] prev1,
                        input logic [127:0] new1, input logic [127:0] new2);
        iFREE = v;
        repeat (8) tick();
        chk("conv_pre_l1", line1, prev1);
        chk1("conv_pre_busy", oBUSY, 1'b1);
        tick();
        chk("conv_l1", line1, new1);
        chk("conv_l2", line2, new2);
        chk1("conv_busy", oBUSY, 1'b0);
    endtask

    initial begin
        iRST_N   = 1'b0;
        iFREE    = 7'd42;
        iCAR_IN  = 1'b0;
        iCAR_OUT = 1'b0;
        iDENIED  = 1'b0;
        repeat (3) tick();
        chk("rst_l1", line1, L1_RST);
        chk("rst_l2", line2, L2_RST);
        chk1("rst_busy", oBUSY, 1'b0);

        iRST_N = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (oBUSY) busy_cnt++;
            if (i == 7) chk("first_pre_l1", line1, L1_RST);
        end
        chkn("first_busy_cycles", busy_cnt, 8);
        chk("first_l1", line1, "FREE SPACES:  42");
        chk("first_l2", line2, L2_OPEN);
        chk1("first_busy_end", oBUSY, 1'b0);

        conv(7'd0,   "FREE SPACES:  42", "FREE SPACES:   0", L2_FULL);
        conv(7'd127, "FREE SPACES:   0", "FREE SPACES: 127", L2_OPEN);
        conv(7'd100, "FREE SPACES: 127", "FREE SPACES: 100", L2_OPEN);

        iCAR_IN = 1'b1;
        tick();
        iCAR_IN = 1'b0;
        chk("ev_in", line2, M_IN);
        repeat (9) tick();
        chk("ev_in_last", line2, M_IN);
        tick();
        chk("ev_in_revert", line2, L2_OPEN);

        iCAR_IN = 1'b1;
        tick();
        iCAR_IN = 1'b0;
        repeat (5) tick();
        chk("ev_restart_pre", line2, M_IN);
        iCAR_OUT = 1'b1;
        tick();
        iCAR_OUT = 1'b0;
        chk("ev_out", line2, M_OUT);
        repeat (9) tick();
        chk("ev_out_last", line2, M_OUT);
        tick();
        chk("ev_out_revert", line2, L2_OPEN);

        iDENIED  = 1'b1;
        iCAR_IN  = 1'b1;
        iCAR_OUT = 1'b1;
        tick();
        iDENIED = 1'b0;
        chk("prio_den", line2, M_DEN);
        tick();
        iCAR_IN  = 1'b0;
        iCAR_OUT = 1'b0;
        chk("prio_in", line2, M_IN);
        repeat (10) tick();
        chk("prio_revert", line2, L2_OPEN);

        iFREE = 7'd10;
        repeat (3) tick();
        iFREE = 7'd99;
        repeat (5) tick();
        iCAR_IN = 1'b1;
        tick();
        iCAR_IN = 1'b0;
        chk("race_l1_10", line1, "FREE SPACES:  10");
        chk("race_l2_ev", line2, M_IN);
        repeat (9) tick();
        chk("race_l1_99", line1, "FREE SPACES:  99");
        chk("race_l2_keep", line2, M_IN);
        tick();
        chk("race_revert", line2, L2_OPEN);

        iCAR_OUT = 1'b1;
        tick();
        iCAR_OUT = 1'b0;
        iFREE = 7'd0;
        repeat (9) tick();
        chk("evfull_l1", line1, "FREE SPACES:   0");
        chk("evfull_l2_ev", line2, M_OUT);
        tick();
        chk("evfull_revert", line2, L2_FULL);

        iFREE   = 7'd55;
        iCAR_IN = 1'b1;
        tick();
        iCAR_IN = 1'b0;
        tick();
        tick();
        chk1("mid_busy", oBUSY, 1'b1);
        #2;
        iRST_N = 1'b0;
        #1;
        chk("async_l1", line1, L1_RST);
        chk("async_l2", line2, L2_RST);
        chk1("async_busy", oBUSY, 1'b0);
        tick();
        iRST_N = 1'b1;
        tick();
        chk1("rerun_busy", oBUSY, 1'b1);
        repeat (7) tick();
        chk("rerun_pre_l1", line1, L1_RST);
        tick();
        chk("rerun_l1", line1, "FREE SPACES:  55");
        chk("rerun_l2", line2, L2_OPEN);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/parking_lcd_text.md
# parking_lcd_text

Text formatter for the parking controller's 16x2 character LCD. It converts the free-space count to right-justified decimal ASCII with a multi-cycle binary-to-BCD converter. It also shows timed event messages (car entered, car exited, entry denied) before reverting to a status line. It sits directly upstream of the LCD sequencer and drives its two 128-bit line inputs. The leftmost character is in bits [127:120], and all characters are ASCII.

## Interface
- HOLD_CYCLES, 50_000_000, number of clock cycles an event message stays on line 2 (1 s at 50 MHz); minimum 2.
- iCLK  input  1  system clock; all state updates on its rising edge.
- iRST_N  input  1  asynchronous active-low reset.
- iFREE  input  7  free-space count, 0..127, stable level from the occupancy counter.
- iCAR_IN  input  1  single-cycle pulse: a car entered.
- iCAR_OUT  input  1  single-cycle pulse: a car left.
- iDENIED  input  1  single-cycle pulse: entry refused.
- line1  output  128  LCD line 1 text, registered.
- line2  output  128  LCD line 2 text, registered.
- oBUSY  output  1  high while a BCD conversion is in flight.

## Operation
- Line 1 format: "FREE SPACES: " followed by 3 digit characters.
  - Digits are right-justified.
  - Leading zeros are blanked to space (0x20); the units digit is always shown.
  - Examples: 5 gives "  5", 0 gives "  0", 127 gives "127".
- Line 2 status format: "STATUS: OPEN    " when the last converted value is nonzero, "STATUS: FULL    " when it is 0.
- Line 2 event messages, each 16 characters, space-padded:
  - "CAR ENTERED     "
  - "CAR EXITED      "
  - "ENTRY DENIED    "
- Conversion FSM states are CIDLE, SHIFT and LOAD. It holds a register last_free and a flag conv_valid, which is cleared by reset.
  - CIDLE: if conv_valid is 0 or iFREE differs from last_free, capture iFREE and clear the BCD accumulator, then go to SHIFT.
  - SHIFT: perform 7 double-dabble iterations, one per cycle. Before each left shift, add 3 to every BCD nibble that is 5 or more. After the 7th iteration, go to LOAD.
  - LOAD: write the 3 digit characters into line1, store last_free, set conv_valid, refresh the status text if the display FSM is in STATUS, then go to CIDLE.
- If iFREE changes during SHIFT or LOAD, the in-flight conversion finishes using the captured value. CIDLE then detects the mismatch and starts a new conversion.
- oBUSY = (state != CIDLE).
- Display FSM states are STATUS and EVENT, with a hold timer wide enough to count to HOLD_CYCLES-1.
  - Any event pulse, in any state, loads the matching message into line2, clears the timer and enters EVENT.
  - Simultaneous pulses resolve by priority: iDENIED, then iCAR_IN, then iCAR_OUT.
  - A new pulse during EVENT restarts the timer with the new message.
  - In EVENT, the timer increments each cycle. On the cycle it equals HOLD_CYCLES-1 with no new pulse, line2 gets the status text for the current last_free and the FSM enters STATUS.
  - While in STATUS, line2 changes only in LOAD.
- Reset values:
  - line1 = "FREE SPACES: ---"
  - line2 = "STATUS: INIT    "
  - oBUSY = 0
  - both FSMs in CIDLE / STATUS
  - timer = 0, last_free = 0, conv_valid = 0
- Reset asserted mid-conversion or mid-event aborts immediately to the reset values. The first cycle after release starts a fresh conversion.

## Timing
- Conversion latency:
  - iFREE changes before edge 0.
  - Edge 0: CIDLE captures the value and enters SHIFT.
  - Edges 1-7: shift iterations.
  - Edge 8: LOAD writes the outputs.
  - line1 and line2 show the new value after edge 8, i.e. 9 edges from edge 0 inclusive.
- oBUSY is high from after edge 0 until after edge 8.
- Back-to-back conversions: minimum spacing is 9 cycles between loads.
- First conversion after reset release: the first edge captures, so line1 shows the real count 9 edges after release.
- Event latency: the pulse sampled at edge e puts the message on line2 after edge e. The message is visible for exactly HOLD_CYCLES cycles, and status returns after edge e+HOLD_CYCLES.
- If LOAD and an event pulse fall on the same edge, the event message wins on line2, and line1 still updates.
- Outputs change only on clock edges, with no combinational paths from inputs to line1 or line2.

## Test plan
- Reset with iFREE=42 held: line1 "FREE SPACES: ---" and line2 "STATUS: INIT    " during reset. After release, edge 8 gives line1 "FREE SPACES:  42" and line2 "STATUS: OPEN    "; oBUSY is high for exactly 8 cycles.
- iFREE 42->0, then 127, then 100: line1 reads "  0" with line2 "STATUS: FULL    ", then "127" with OPEN, then "100". Each result appears exactly 9 edges after its change.
- HOLD_CYCLES=10, iCAR_IN pulse: line2 "CAR ENTERED     " for exactly 10 cycles, then "STATUS: OPEN    ". A second iCAR_OUT pulse at hold cycle 6 gives "CAR EXITED      " for a full 10 cycles.
- iDENIED, iCAR_IN and iCAR_OUT pulsed in the same cycle: line2 "ENTRY DENIED    ". iCAR_IN with iCAR_OUT gives "CAR ENTERED     ".
- iFREE 10->99 at conversion edge 3, with iCAR_IN arriving at the LOAD edge:
  - line1 briefly shows " 10", then " 99" after a second conversion;
  - line2 keeps the event text;
  - on reverting, line2 shows status for 99.
- Reset asserted mid-SHIFT and mid-EVENT: outputs return to reset values asynchronously; after release, the conversion restarts and matches iFREE.
